uart_rx_buffered: RTL and testbench

- Serial receive end of the UART link: deserialises 8N1 frames from `ser_rx`.
- Majority-votes each bit at mid-bit.
- Queues good bytes in a small FIFO, presented on a valid/ready output.
- Keeps a running 32-bit checksum of consumed bytes, for loopback tests against the existing transmit path (uart_top).

---
 rtl/uart_rx_buffered.sv | 253 +++++++++++++++++++++++++
 tb/tb_uart_rx_buffered.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_buffered.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_buffered
// Purpose  : 8N1 UART receiver with a 2-flop synchroniser, 3-sample majority
//            vote at mid-bit, a small byte FIFO on a valid/ready output and a
//            running 32-bit checksum of consumed bytes.
// Options  : define UART_RX_PARITY_EN for one even-parity bit between the
//            data and the stop bit (11-bit frames, parity_err reported).
//            Undefined: 10-bit 8N1 frames, parity_err tied low.
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx_buffered #(
  parameter int CLOCKS_PER_BIT = 3,   // >= 3
  parameter int FIFO_DEPTH     = 4    // power of two, >= 2
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          ser_rx,
  output logic [7:0]                    out_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [$clog2(FIFO_DEPTH):0]   out_count,
  output logic                          frame_err,
  output logic                          overrun,
  output logic                          parity_err,
  output logic [31:0]                   out_sum
);

  localparam int c_TICK_W = $clog2(CLOCKS_PER_BIT);
  localparam int c_ADDR_W = $clog2(FIFO_DEPTH);
  localparam int c_CNT_W  = c_ADDR_W + 1;
  localparam int c_MID    = CLOCKS_PER_BIT / 2;

  // Sample points around mid-bit; the vote is resolved on the third sample.
  localparam logic [c_TICK_W-1:0] c_TICK_S0   = c_TICK_W'(c_MID - 1);
  localparam logic [c_TICK_W-1:0] c_TICK_S1   = c_TICK_W'(c_MID);
  localparam logic [c_TICK_W-1:0] c_TICK_DEC  = c_TICK_W'(c_MID + 1);
  localparam logic [c_TICK_W-1:0] c_TICK_LAST = c_TICK_W'(CLOCKS_PER_BIT - 1);
  localparam logic [c_CNT_W-1:0]  c_FULL      = c_CNT_W'(FIFO_DEPTH);

  localparam logic [2:0] c_ST_IDLE   = 3'd0;
  localparam logic [2:0] c_ST_START  = 3'd1;
  localparam logic [2:0] c_ST_DATA   = 3'd2;
`ifdef UART_RX_PARITY_EN
  localparam logic [2:0] c_ST_PARITY = 3'd3;
`endif
  localparam logic [2:0] c_ST_STOP   = 3'd4;
  localparam logic [2:0] c_ST_BREAK  = 3'd5;

  logic [1:0]          r_sync;
  logic                w_rx_s;
  logic [2:0]          r_state;
  logic [c_TICK_W-1:0] r_tick;
  logic [2:0]          r_bit;
  logic [7:0]          r_shift;
  logic                r_samp0;
  logic                r_samp1;
  logic                w_maj;
  logic                w_decide;
  logic                w_bit_end;
  logic                w_stop_dec;
  logic                w_par_bad;
  logic                w_full;
  logic                w_pop;
  logic                w_push;
  logic [7:0]          r_mem [FIFO_DEPTH];
  logic [c_ADDR_W-1:0] r_wr_ptr;
  logic [c_ADDR_W-1:0] r_rd_ptr;
  logic [c_CNT_W-1:0]  r_count;
  logic [31:0]         r_sum;
  logic                r_frame_err;
  logic                r_overrun;

  // Two-flop synchroniser; resets high so reset never looks like a start bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= 2'b11;
    end else begin
      r_sync <= {r_sync[0], ser_rx};
    end
  end

  assign w_rx_s     = r_sync[1];
  assign w_maj      = (r_samp0 & r_samp1) | (r_samp0 & w_rx_s) | (r_samp1 & w_rx_s);
  assign w_decide   = (r_tick == c_TICK_DEC);
  assign w_bit_end  = (r_tick == c_TICK_LAST);
  assign w_full     = (r_count == c_FULL);
  assign out_valid  = (r_count != '0);
  assign w_pop      = out_valid && out_ready;
  assign w_stop_dec = (r_state == c_ST_STOP) && w_decide;
  // A full FIFO still accepts the byte when the head leaves in the same cycle.
  assign w_push     = w_stop_dec && w_maj && !w_par_bad && (!w_full || w_pop);

  // Frame sequencer. IDLE and BREAK hold tick at 0, so the IDLE cycle that
  // detects the start edge doubles as tick 0 (and sample 0 when mid is 1).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= c_ST_IDLE;
      r_tick  <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_samp0 <= 1'b1;
      r_samp1 <= 1'b1;
    end else begin
      if (r_tick == c_TICK_S0) r_samp0 <= w_rx_s;
      if (r_tick == c_TICK_S1) r_samp1 <= w_rx_s;
      case (r_state)
        c_ST_IDLE: begin
          if (!w_rx_s) begin
            r_state <= c_ST_START;
            r_tick  <= c_TICK_W'(1);
          end
        end
        c_ST_START: begin
          if (w_decide && w_maj) begin
            r_state <= c_ST_IDLE;       // glitch, not a real start bit
            r_tick  <= '0;
          end else if (w_bit_end) begin
            r_state <= c_ST_DATA;
            r_tick  <= '0;
            r_bit   <= '0;
          end else begin
            r_tick  <= r_tick + c_TICK_W'(1);
          end
        end
        c_ST_DATA: begin
          if (w_decide) r_shift <= {w_maj, r_shift[7:1]};
          if (w_bit_end) begin
            r_tick <= '0;
            if (r_bit == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              r_state <= c_ST_PARITY;
`else
              r_state <= c_ST_STOP;
`endif
            end else begin
              r_bit <= r_bit + 3'd1;
            end
          end else begin
            r_tick <= r_tick + c_TICK_W'(1);
          end
        end
`ifdef UART_RX_PARITY_EN
        c_ST_PARITY: begin
          if (w_bit_end) begin
            r_state <= c_ST_STOP;
            r_tick  <= '0;
          end else begin
            r_tick  <= r_tick + c_TICK_W'(1);
          end
        end
`endif
        c_ST_STOP: begin
          // Leave at the decision rather than the end of the stop bit so the
          // next start edge is never missed.
          if (w_decide) begin
            r_state <= w_maj ? c_ST_IDLE : c_ST_BREAK;
            r_tick  <= '0;
          end else begin
            r_tick  <= r_tick + c_TICK_W'(1);
          end
        end
        c_ST_BREAK: begin
          if (w_rx_s) r_state <= c_ST_IDLE;
        end
        default: begin
          r_state <= c_ST_IDLE;
          r_tick  <= '0;
        end
      endcase
    end
  end

`ifdef UART_RX_PARITY_EN
  logic r_par_bad;
  logic r_parity_err;

  // Even parity: latch a mismatch at the parity-bit decision.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_par_bad <= 1'b0;
    end else if ((r_state == c_ST_PARITY) && w_decide) begin
      r_par_bad <= w_maj ^ (^r_shift);
    end
  end

  // Parity error is reported only for a good stop bit; framing wins otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_parity_err <= 1'b0;
    end else begin
      r_parity_err <= w_stop_dec && w_maj && r_par_bad;
    end
  end

  assign w_par_bad  = r_par_bad;
  assign parity_err = r_parity_err;
`else
  assign w_par_bad  = 1'b0;
  assign parity_err = 1'b0;
`endif

  // One-cycle status pulses raised by the stop-bit decision.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_frame_err <= w_stop_dec && !w_maj;
      r_overrun   <= w_stop_dec && w_maj && !w_par_bad && w_full && !w_pop;
    end
  end

  assign frame_err = r_frame_err;
  assign overrun   = r_overrun;

  // Circular byte FIFO; pointers wrap naturally because the depth is 2^n.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= r_shift;
        r_wr_ptr        <= r_wr_ptr + c_ADDR_W'(1);
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + c_ADDR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + c_CNT_W'(1);
        2'b01:   r_count <= r_count - c_CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign out_data  = r_mem[r_rd_ptr];
  assign out_count = r_count;

  // Running checksum of every byte the consumer takes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sum <= '0;
    end else if (w_pop) begin
      r_sum <= r_sum + {24'b0, out_data};
    end
  end

  assign out_sum = r_sum;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_buffered.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_rx_buffered
// Purpose  : Self-checking bench for uart_rx_buffered. A queue-based model
//            predicts each frame's outcome at a fixed offset from its start
//            edge; outputs are compared every cycle, plus literal checks.
// Options  : honours UART_RX_PARITY_EN (11-bit frames, parity cases).
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_rx_buffered;

  localparam int CPB   = 3;
  localparam int DEPTH = 4;
  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam int MID   = CPB / 2;
`ifdef UART_RX_PARITY_EN
  localparam int STOP_IDX = 10;
`else
  localparam int STOP_IDX = 9;
`endif
  // Edge (counted from the edge the start bit is driven after) at which a
  // frame's outcome becomes visible: 2 sync flops, then the stop-bit vote.
  localparam int OFF = 4 + STOP_IDX * CPB + MID;

  localparam int K_GOOD  = 0;
  localparam int K_FRAME = 1;
  localparam int K_PAR   = 2;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             ser_rx = 1'b1;
  logic             out_ready = 1'b0;
  logic [7:0]       out_data;
  logic             out_valid;
  logic [CNT_W-1:0] out_count;
  logic             frame_err;
  logic             overrun;
  logic             parity_err;
  logic [31:0]      out_sum;

  uart_rx_buffered #(.CLOCKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ser_rx     (ser_rx),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_count  (out_count),
    .frame_err  (frame_err),
    .overrun    (overrun),
    .parity_err (parity_err),
    .out_sum    (out_sum)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    int         at;
    int         kind;
    logic [7:0] data;
  } ev_t;

  ev_t         sched[$];
  logic [7:0]  m_q[$];
  logic [31:0] m_sum = '0;
  bit          m_fe = 1'b0;
  bit          m_ov = 1'b0;
  bit          m_pe = 1'b0;
  int          cyc = 0;

  // Model: FIFO as a queue, frame outcomes applied at their scheduled edge.
  always @(posedge clk or negedge rst_n) begin
    bit  pop;
    bit  full;
    ev_t e;
    if (!rst_n) begin
      m_q.delete();
      sched.delete();
      m_sum = '0;
      m_fe  = 1'b0;
      m_ov  = 1'b0;
      m_pe  = 1'b0;
    end else begin
      cyc++;
      m_fe = 1'b0;
      m_ov = 1'b0;
      m_pe = 1'b0;
      full = (m_q.size() == DEPTH);
      pop  = (m_q.size() != 0) && out_ready;
      if (pop) m_sum = m_sum + {24'b0, m_q.pop_front()};
      while (sched.size() != 0 && sched[0].at <= cyc) begin
        e = sched.pop_front();
        if (e.kind == K_FRAME) m_fe = 1'b1;
        else if (e.kind == K_PAR) m_pe = 1'b1;
        else if (!full || pop) m_q.push_back(e.data);
        else m_ov = 1'b1;
      end
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    chk("out_valid", 32'(out_valid), 32'(m_q.size() != 0));
    chk("out_count", 32'(out_count), 32'(m_q.size()));
    if (m_q.size() != 0) chk("out_data", 32'(out_data), 32'(m_q[0]));
    chk("out_sum", out_sum, m_sum);
    chk("frame_err", 32'(frame_err), 32'(m_fe));
    chk("overrun", 32'(overrun), 32'(m_ov));
    chk("parity_err", 32'(parity_err), 32'(m_pe));
  end

  // Pulse tallies for the literal checks.
  int cnt_fe = 0;
  int cnt_ov = 0;
  int cnt_pe = 0;
  always @(negedge clk) begin
    if (frame_err)  cnt_fe++;
    if (overrun)    cnt_ov++;
    if (parity_err) cnt_pe++;
  end

  // ---------------- stimulus ----------------
  bit rand_ready = 1'b0;

  task automatic tick_n(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      if (rand_ready) out_ready = ($urandom_range(0, 1) == 1);
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input bit stop_ok, input bit par_flip,
                            input int extra_low);
    logic [11:0] bits;
    int          nb;
    ev_t         e;
    bits    = '0;
    bits[0] = 1'b0;
    bits[8:1] = d;
`ifdef UART_RX_PARITY_EN
    bits[9]  = (^d) ^ par_flip;
    bits[10] = stop_ok;
    nb       = 11;
    e.kind   = !stop_ok ? K_FRAME : (par_flip ? K_PAR : K_GOOD);
`else
    bits[9]  = stop_ok;
    nb       = 10;
    e.kind   = !stop_ok ? K_FRAME : K_GOOD;
`endif
    e.at   = cyc + OFF;
    e.data = d;
    sched.push_back(e);
    for (int j = 0; j < nb; j++) begin
      ser_rx = bits[j];
      tick_n(CPB);
    end
    if (extra_low > 0) begin
      ser_rx = 1'b0;
      tick_n(extra_low);
    end
    ser_rx = 1'b1;
  endtask

  initial begin
    int          n_val;
    logic [7:0]  got;
    logic [31:0] sum_b;
    int          fe_b;
    int          ov_b;
    int          r;
    bit          sok;
    bit          pf;

    tick_n(3);
    // Reset state
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_count", 32'(out_count), 32'd0);
    chk("rst_data", 32'(out_data), 32'd0);
    chk("rst_sum", out_sum, 32'd0);
    rst_n = 1'b1;
    tick_n(4);

    // 1: single byte, consumer always ready
    out_ready = 1'b1;
    send_frame(8'h48, 1'b1, 1'b0, 0);
    n_val = 0;
    got   = '0;
    for (int i = 0; i < 40; i++) begin
      tick_n(1);
      if (out_valid) begin
        n_val++;
        got = out_data;
      end
    end
    chk("t1_valid_cycles", 32'(n_val), 32'd1);
    chk("t1_data", 32'(got), 32'h48);
    chk("t1_sum", out_sum, 32'h48);
    chk("t1_no_frame_err", 32'(cnt_fe), 32'd0);

    // 2: one-cycle glitch then 0x69
    ser_rx = 1'b0;
    tick_n(1);
    ser_rx = 1'b1;
    tick_n(6);
    chk("t2_glitch_count", 32'(out_count), 32'd0);
    send_frame(8'h69, 1'b1, 1'b0, 0);
    tick_n(OFF);
    chk("t2_sum", out_sum, 32'h48 + 32'h69);
    chk("t2_no_frame_err", 32'(cnt_fe), 32'd0);

    // 3: bad stop bit with a held-low line, then 0x41
    fe_b = cnt_fe;
    send_frame(8'h55, 1'b0, 1'b0, 20);
    tick_n(4);
    send_frame(8'h41, 1'b1, 1'b0, 0);
    tick_n(OFF);
    chk("t3_one_frame_err", 32'(cnt_fe - fe_b), 32'd1);
    chk("t3_sum", out_sum, 32'hF2);

    // 4: fill the FIFO, overflow on the fifth byte, then drain
    out_ready = 1'b0;
    tick_n(1);
    sum_b = out_sum;
    ov_b  = cnt_ov;
    for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b1, 1'b0, 0);
    tick_n(OFF);
    chk("t4_count_full", 32'(out_count), 32'd4);
    chk("t4_head", 32'(out_data), 32'h01);
    chk("t4_one_overrun", 32'(cnt_ov - ov_b), 32'd1);
    out_ready = 1'b1;
    tick_n(8);
    chk("t4_sum_delta", out_sum - sum_b, 32'h0A);
    chk("t4_drained", 32'(out_count), 32'd0);

`ifdef UART_RX_PARITY_EN
    // 6: parity mismatch discards, matching parity accepts
    out_ready = 1'b0;
    fe_b = cnt_pe;
    send_frame(8'h03, 1'b1, 1'b1, 0);
    tick_n(OFF);
    chk("t6_parity_err", 32'(cnt_pe - fe_b), 32'd1);
    chk("t6_not_queued", 32'(out_count), 32'd0);
    send_frame(8'h03, 1'b1, 1'b0, 0);
    tick_n(OFF);
    chk("t6_queued", 32'(out_count), 32'd1);
    chk("t6_data", 32'(out_data), 32'h03);
    out_ready = 1'b1;
    tick_n(2);
`endif

    // 5: asynchronous reset in the middle of a data bit
    out_ready = 1'b0;
    send_frame(8'h33, 1'b1, 1'b0, 0);
    tick_n(OFF);
    chk("t5_pre_count", 32'(out_count), 32'd1);
    ser_rx = 1'b0;
    tick_n(CPB);
    tick_n(CPB);
    ser_rx = 1'b1;
    tick_n(CPB);
    ser_rx = 1'b0;
    tick_n(1);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_rst_valid", 32'(out_valid), 32'd0);
    chk("t5_rst_count", 32'(out_count), 32'd0);
    chk("t5_rst_data", 32'(out_data), 32'd0);
    chk("t5_rst_sum", out_sum, 32'd0);
    ser_rx = 1'b1;
    tick_n(2);
    rst_n = 1'b1;
    tick_n(4);
    out_ready = 1'b1;
    send_frame(8'h7E, 1'b1, 1'b0, 0);
    tick_n(OFF);
    chk("t5_after_sum", out_sum, 32'h7E);

    // Randomized traffic with a randomly stalling consumer
    rand_ready = 1'b1;
    for (int k = 0; k < 80; k++) begin
      r   = $urandom_range(0, 15);
      sok = (r != 1);
      pf  = (r == 2);
      if (r == 0) begin
        ser_rx = 1'b0;
        tick_n(1);
        ser_rx = 1'b1;
        tick_n(4);
      end
      send_frame(8'($urandom), sok, pf, sok ? 0 : $urandom_range(0, 6));
      tick_n(sok ? $urandom_range(0, 3) : $urandom_range(2, 5));
    end
    rand_ready = 1'b0;
    tick_n(1);
    out_ready = 1'b1;
    tick_n(OFF + 10);
    chk("end_empty", 32'(out_count), 32'd0);
    chk("end_valid", 32'(out_valid), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
